alu_share_arb: RTL and testbench

// Shares one combinational 32-bit ALU (ADD/SUB/AND/ORR, NZCV flags) between two requesters, e.g. the main datapath and the address-generation unit.
// Per-requester valid/ready issue port, round-robin or fixed-priority grant, one registered response buffer per requester.

---
 rtl/alu_share_arb.sv | 151 +++++++++++++++
 tb/tb_alu_share_arb.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// alu_share_arb: arbitrates two requesters onto one shared combinational ALU.
// Each requester gets a registered one-entry response buffer. The block also
// owns the architectural NZCV flags register.

// One-entry response buffer. A load takes priority over a pop.
module alu_rsp_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             pop,
  input  logic [WIDTH-1:0] d_result,
  input  logic [3:0]       d_flags,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);
  // A load on a transfer wins over a pop, so the buffer sustains 1 op/cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid  <= 1'b0;
      result <= '0;
      flags  <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      result <= d_result;
      flags  <= d_flags;
    end else if (pop) begin
      valid  <= 1'b0;
    end
  end
endmodule

module alu_share_arb #(
  parameter int WIDTH     = 32,
  parameter int FIXED_PRI = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_src_a,
  input  logic [WIDTH-1:0] req0_src_b,
  input  logic [1:0]       req0_alu_control,
  input  logic             req0_set_flags,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_src_a,
  input  logic [WIDTH-1:0] req1_src_b,
  input  logic [1:0]       req1_alu_control,
  input  logic             req1_set_flags,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic [3:0]       rsp0_flags,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic [3:0]       rsp1_flags,
  output logic [WIDTH-1:0] alu_src_a,
  output logic [WIDTH-1:0] alu_src_b,
  output logic [1:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic [3:0]       flags
);
  typedef struct packed {
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [1:0]       ctl;
    logic             set_flags;
  } req_t;

  req_t [1:0]             req;
  logic [1:0]             req_valid, rsp_ready, rsp_valid, elig, grant;
  logic [1:0][WIDTH-1:0]  rsp_result;
  logic [1:0][3:0]        rsp_flags;
  logic                   rr_last;  // id of the last winner; 1 after reset so req0 wins the first tie
  logic                   do_flags;

  assign req[0]    = '{src_a: req0_src_a, src_b: req0_src_b, ctl: req0_alu_control, set_flags: req0_set_flags};
  assign req[1]    = '{src_a: req1_src_a, src_b: req1_src_b, ctl: req1_alu_control, set_flags: req1_set_flags};
  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // A requester can issue only when its buffer is empty or is draining this cycle.
  assign elig = req_valid & (~rsp_valid | rsp_ready);

  // Single grant per cycle. No grant is made while reset is asserted, so no transfer is seen.
  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      if (elig == 2'b11) grant = (FIXED_PRI != 0 || rr_last) ? 2'b01 : 2'b10;
      else               grant = elig;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // Drive the shared ALU from the winner, or with zeros when idle.
  always_comb begin
    alu_src_a   = '0;
    alu_src_b   = '0;
    alu_control = 2'b00;
    if (grant[0]) begin
      alu_src_a   = req[0].src_a;
      alu_src_b   = req[0].src_b;
      alu_control = req[0].ctl;
    end else if (grant[1]) begin
      alu_src_a   = req[1].src_a;
      alu_src_b   = req[1].src_b;
      alu_control = req[1].ctl;
    end
  end

  assign do_flags = (grant[0] & req[0].set_flags) | (grant[1] & req[1].set_flags);

  // Record the round-robin winner and update the architectural flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last <= 1'b1;
      flags   <= 4'b0000;
    end else begin
      if (|grant) rr_last <= grant[1];
      if (do_flags) flags <= alu_flags;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_buf
    alu_rsp_buf #(.WIDTH(WIDTH)) u_buf (
      .clk      (clk),
      .reset    (reset),
      .load     (grant[i]),
      .pop      (rsp_ready[i]),
      .d_result (alu_result),
      .d_flags  (alu_flags),
      .valid    (rsp_valid[i]),
      .result   (rsp_result[i]),
      .flags    (rsp_flags[i])
    );
  end

  assign rsp0_valid  = rsp_valid[0];
  assign rsp1_valid  = rsp_valid[1];
  assign rsp0_result = rsp_result[0];
  assign rsp1_result = rsp_result[1];
  assign rsp0_flags  = rsp_flags[0];
  assign rsp1_flags  = rsp_flags[1];
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: randomized and directed check of alu_share_arb against a behavioural model.
module tb_alu_share_arb;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Reference ALU: {N,Z,C,V, result}. C on subtract means "no borrow" (a >= b).
  function automatic logic [35:0] alu_fn(input logic [31:0] x, input logic [31:0] y, input logic [1:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic cf, vf;
    s = '0; r = '0; cf = 1'b0; vf = 1'b0;
    case (op)
      2'd0: begin s = {1'b0, x} + {1'b0, y}; r = s[31:0]; cf = s[32]; vf = (x[31] == y[31]) && (r[31] != x[31]); end
      2'd1: begin r = x - y; cf = (x >= y); vf = (x[31] != y[31]) && (r[31] != x[31]); end
      2'd2: r = x & y;
      default: r = x | y;
    endcase
    return {r[31], (r == 32'd0), cf, vf, r};
  endfunction

  // ---------------- main DUT (round robin) ----------------
  logic        v[2], sf[2], rr[2];
  logic [31:0] a[2], b[2];
  logic [1:0]  c[2];
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_result, rsp1_result, alu_src_a, alu_src_b, alu_result;
  logic [3:0]  rsp0_flags, rsp1_flags, alu_flags, flags;
  logic [1:0]  alu_control;

  assign {alu_flags, alu_result} = alu_fn(alu_src_a, alu_src_b, alu_control);

  alu_share_arb #(.WIDTH(32), .FIXED_PRI(0)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(v[0]), .req0_ready(req0_ready), .req0_src_a(a[0]), .req0_src_b(b[0]),
    .req0_alu_control(c[0]), .req0_set_flags(sf[0]),
    .req1_valid(v[1]), .req1_ready(req1_ready), .req1_src_a(a[1]), .req1_src_b(b[1]),
    .req1_alu_control(c[1]), .req1_set_flags(sf[1]),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rr[0]), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rr[1]), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_flags(alu_flags), .flags(flags)
  );

  // ---------------- second DUT (fixed priority) ----------------
  logic        fv[2], fr[2];
  logic        f_rdy0, f_rdy1, f_rv0, f_rv1;
  logic [31:0] f_res0, f_res1, f_sa, f_sb, f_ar;
  logic [3:0]  f_fl0, f_fl1, f_af, f_flags;
  logic [1:0]  f_ctl;

  assign {f_af, f_ar} = alu_fn(f_sa, f_sb, f_ctl);

  alu_share_arb #(.WIDTH(32), .FIXED_PRI(1)) dut_fp (
    .clk(clk), .reset(reset),
    .req0_valid(fv[0]), .req0_ready(f_rdy0), .req0_src_a(32'd20), .req0_src_b(32'd22),
    .req0_alu_control(2'd0), .req0_set_flags(1'b0),
    .req1_valid(fv[1]), .req1_ready(f_rdy1), .req1_src_a(32'd9), .req1_src_b(32'd4),
    .req1_alu_control(2'd1), .req1_set_flags(1'b1),
    .rsp0_valid(f_rv0), .rsp0_ready(fr[0]), .rsp0_result(f_res0), .rsp0_flags(f_fl0),
    .rsp1_valid(f_rv1), .rsp1_ready(fr[1]), .rsp1_result(f_res1), .rsp1_flags(f_fl1),
    .alu_src_a(f_sa), .alu_src_b(f_sb), .alu_control(f_ctl),
    .alu_result(f_ar), .alu_flags(f_af), .flags(f_flags)
  );

  // ---------------- behavioural model state ----------------
  logic        m_val[2];
  logic [31:0] m_res[2];
  logic [3:0]  m_flg[2];
  logic [3:0]  m_flags;
  int          m_last;     // requester that won most recently
  int          last_w;     // winner of the most recent cycle (-1 none)
  logic        g0, g1;     // DUT ready values sampled in the most recent cycle
  int          checks = 0;
  int          passes = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drv(input int n, input logic vv, input logic [31:0] aa, input logic [31:0] bb,
                     input logic [1:0] cc, input logic ss);
    v[n] = vv; a[n] = aa; b[n] = bb; c[n] = cc; sf[n] = ss;
  endtask

  // One clock cycle: compare every DUT output with the model, then advance the model.
  task automatic step();
    int          w;
    logic        e0, e1;
    logic [35:0] o;
    logic [31:0] ea, eb;
    logic [1:0]  ec;
    #3;
    g0 = req0_ready;
    g1 = req1_ready;
    e0 = v[0] && (!m_val[0] || rr[0]);
    e1 = v[1] && (!m_val[1] || rr[1]);
    w = -1;
    if (!reset) begin
      if (e0 && e1) w = (m_last == 0) ? 1 : 0;
      else if (e0)  w = 0;
      else if (e1)  w = 1;
    end
    ea = '0; eb = '0; ec = '0;
    if (w >= 0) begin ea = a[w]; eb = b[w]; ec = c[w]; end
    chk("req0_ready", req0_ready, w == 0);
    chk("req1_ready", req1_ready, w == 1);
    chk("alu_src_a", alu_src_a, ea);
    chk("alu_src_b", alu_src_b, eb);
    chk("alu_control", alu_control, ec);
    chk("rsp0_valid", rsp0_valid, m_val[0]);
    chk("rsp1_valid", rsp1_valid, m_val[1]);
    chk("rsp0_result", rsp0_result, m_res[0]);
    chk("rsp1_result", rsp1_result, m_res[1]);
    chk("rsp0_flags", rsp0_flags, m_flg[0]);
    chk("rsp1_flags", rsp1_flags, m_flg[1]);
    chk("flags", flags, m_flags);
    @(posedge clk);
    if (reset) begin
      for (int n = 0; n < 2; n++) begin m_val[n] = 0; m_res[n] = '0; m_flg[n] = '0; end
      m_flags = '0;
      m_last = 1;
    end else begin
      for (int n = 0; n < 2; n++)
        if (w != n && m_val[n] && rr[n]) m_val[n] = 0;
      if (w >= 0) begin
        o = alu_fn(a[w], b[w], c[w]);
        m_val[w] = 1; m_res[w] = o[31:0]; m_flg[w] = o[35:32];
        if (sf[w]) m_flags = o[35:32];
        m_last = w;
      end
    end
    last_w = w;
    #1;
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return $urandom_range(3);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [1:0] seq [4];
    reset = 1'b1;
    for (int n = 0; n < 2; n++) begin drv(n, 0, 0, 0, 0, 0); rr[n] = 0; fv[n] = 0; fr[n] = 0; end
    v[0] = 1;  // ready must still stay low during reset
    for (int n = 0; n < 2; n++) begin m_val[n] = 0; m_res[n] = '0; m_flg[n] = '0; end
    m_flags = '0; m_last = 1; last_w = -1;
    @(posedge clk); #1;
    step();
    step();
    chk("reset_ready0", g0, 1'b0);
    chk("reset_rsp0_valid", rsp0_valid, 1'b0);
    chk("reset_flags", flags, 4'b0000);
    reset = 1'b0;
    v[0] = 0;

    // add 5+3 with set_flags
    drv(0, 1, 32'd5, 32'd3, 2'd0, 1); rr[0] = 1; rr[1] = 1;
    step();
    chk("add_granted", g0, 1'b1);
    v[0] = 0;
    chk("add_rsp_valid", rsp0_valid, 1'b1);
    chk("add_result", rsp0_result, 32'd8);
    chk("add_rsp_flags", rsp0_flags, 4'b0000);
    chk("add_flags", flags, 4'b0000);
    step();

    // round robin: req0 won last, so req1 takes the first tie
    drv(0, 1, 32'd7, 32'd7, 2'd1, 0);        // 7-7 with no flag update
    drv(1, 1, 32'hF0F0_0000, 32'hFF00_0000, 2'd2, 1);
    for (int i = 0; i < 4; i++) begin step(); seq[i] = {g1, g0}; end
    chk("rr_seq0", seq[0], 2'b10);
    chk("rr_seq1", seq[1], 2'b01);
    chk("rr_seq2", seq[2], 2'b10);
    chk("rr_seq3", seq[3], 2'b01);
    chk("rr_flags_and", flags, 4'b1000);
    v[0] = 0; v[1] = 0;
    step();

    // sub 0x80000000-1 sets V and C; a later orr without set_flags leaves them
    drv(1, 1, 32'h8000_0000, 32'd1, 2'd1, 1);
    step();
    v[1] = 0;
    chk("sub_result", rsp1_result, 32'h7FFF_FFFF);
    chk("sub_flags", flags, 4'b0011);
    drv(0, 1, 32'h0000_00F0, 32'h0000_000F, 2'd3, 0);
    step();
    v[0] = 0;
    chk("orr_result", rsp0_result, 32'h0000_00FF);
    chk("orr_flags_held", flags, 4'b0011);
    step();

    // stall: rsp0 full and not drained, req1 keeps winning
    rr[0] = 0; rr[1] = 1;
    drv(0, 1, 32'd10, 32'd12, 2'd2, 0);
    drv(1, 1, 32'd1, 32'd2, 2'd0, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      if (i >= 2) begin
        chk("stall_ready0", g0, 1'b0);
        chk("stall_ready1", g1, 1'b1);
        chk("stall_rsp0_held", rsp0_result, 32'd8);
      end
    end
    rr[0] = 1;
    step();
    chk("stall_release", g0, 1'b1);
    v[0] = 0; v[1] = 0;
    step();

    // randomized traffic, honouring input stability while stalled
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (!(v[n] && last_w != n))
          drv(n, $urandom_range(3) != 0, rnd32(), rnd32(), 2'($urandom_range(3)), 1'($urandom_range(1)));
        rr[n] = $urandom_range(9) < 7;
      end
      step();
    end

    // reset with both buffers full and a transfer pending
    rr[0] = 0; rr[1] = 0;
    v[0] = 0; v[1] = 0;
    step();
    rr[0] = 1; rr[1] = 1;
    step();
    rr[0] = 0; rr[1] = 0;
    drv(0, 1, 32'd1, 32'd2, 2'd0, 0);
    drv(1, 1, 32'd0, 32'd1, 2'd1, 1);         // 0-1: N set, borrow
    step();
    step();
    chk("pre_reset_flags", flags, 4'b1000);
    chk("pre_reset_full", {rsp1_valid, rsp0_valid}, 2'b11);
    rr[0] = 1;
    reset = 1'b1;
    step();
    chk("rst_ready0", g0, 1'b0);
    chk("rst_ready1", g1, 1'b0);
    reset = 1'b0;
    v[0] = 0; v[1] = 0;
    chk("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk("rst_flags", flags, 4'b0000);
    step();

    // fixed priority: req0 wins every tie while eligible
    fv[0] = 1; fv[1] = 1; fr[0] = 1; fr[1] = 1;
    for (int i = 0; i < 8; i++) begin
      #3;
      chk("fp_ready0", f_rdy0, 1'b1);
      chk("fp_ready1", f_rdy1, 1'b0);
      @(posedge clk); #1;
    end
    chk("fp_result0", f_res0, 32'd42);
    fr[0] = 0;  // rsp0 full and held, so req0 drops out and req1 wins
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("fp_blocked_ready1", f_rdy1, 1'b1);
      chk("fp_blocked_ready0", f_rdy0, 1'b0);
      @(posedge clk); #1;
    end
    chk("fp_result1", f_res1, 32'd5);
    chk("fp_flags", f_flags, 4'b0010);
    fr[0] = 1;
    #3;
    chk("fp_resume_ready0", f_rdy0, 1'b1);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
